// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serial bit-pattern matcher that scans DATA_W-bit words MSB first
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cfg_we/cfg_pattern/cfg_len/cfg_overlap  pattern configuration, accepted only in IDLE
//   in_valid/in_data/in_ready               word input handshake
//   out_valid/out_ready/out_mask/out_count  per-word match mask and match count
//   total_count         saturating match count since reset or last config write
//   busy                high whenever the FSM is not IDLE
module pattern_scan_ctrl #(
  parameter int DATA_W = 16,
  localparam int CW = $clog2(DATA_W + 1),
  localparam int IW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mask,
  output logic [CW-1:0]     out_count,
  output logic [15:0]       total_count,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, mask_q, mask_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] total_q, total_d;
  logic [7:0] hist_q, hist_d, pat_q, pat_d, hist_n, len_mask;
  logic [3:0] len_q, len_d;
  logic ovl_q, ovl_d, match, accept, cfg_ok;
  assign in_ready = state_q == IDLE && !cfg_we;
  assign accept = in_valid && in_ready;
  assign cfg_ok = state_q == IDLE && cfg_we;
  assign hist_n = {hist_q[6:0], data_q[DATA_W-1]};
  assign len_mask = 8'hFF >> (4'd8 - len_q);
  assign match = state_q == SCAN && ((hist_n ^ pat_q) & len_mask) == 8'h0;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_mask = mask_q;
  assign out_count = count_q;
  assign total_count = total_q;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    mask_d = mask_q;
    idx_d = idx_q;
    count_d = count_q;
    total_d = total_q;
    hist_d = hist_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    if (cfg_ok) begin
      pat_d = cfg_pattern;
      len_d = cfg_len < 4'd2 ? 4'd2 : cfg_len > 4'd8 ? 4'd8 : cfg_len;
      ovl_d = cfg_overlap;
      hist_d = 8'h0;
      total_d = 16'h0;
    end
    if (accept) begin
      data_d = in_data;
      idx_d = IW'(DATA_W - 1);
      mask_d = '0;
      count_d = '0;
      state_d = SCAN;
    end
    if (state_q == SCAN) begin
      data_d = data_q << 1;
      // non-overlapping mode restarts matching from an empty history
      hist_d = match && !ovl_q ? 8'h0 : hist_n;
      idx_d = idx_q - IW'(1);
      mask_d = match ? mask_q | (DATA_W'(1) << idx_q) : mask_q;
      count_d = count_q + CW'(match);
      total_d = total_q + 16'(match && total_q != 16'hFFFF);
      state_d = idx_q == '0 ? DONE : SCAN;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      mask_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      total_q <= 16'h0;
      hist_q <= 8'h0;
      pat_q <= 8'b101;
      len_q <= 4'd3;
      ovl_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      count_q <= count_d;
      total_q <= total_d;
      hist_q <= hist_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;
  logic clk = 0, reset = 1, cfg_we = 0, cfg_overlap = 0, in_valid = 0, out_ready = 0;
  logic [7:0] cfg_pattern = 0;
  logic [3:0] cfg_len = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] out_mask, total_count;
  logic [4:0] out_count;
  int checks = 0, errors = 0;
  pattern_scan_ctrl #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_count(out_count),
    .total_count(total_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [15:0] w);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick;
      k++;
    end
    chk("ready_wait", 32'(in_ready), 1);
    in_valid = 1;
    in_data = w;
    tick;
    in_valid = 0;
    in_data = 16'($urandom);
  endtask
  task automatic wait_done(input int k0);
    int k = k0;
    while (!out_valid && k < 40) begin
      tick;
      k++;
    end
    chk("latency", k, 17);
  endtask
  task automatic result(input string tag, input logic [15:0] m, input logic [4:0] c, input logic [15:0] t);
    chk({tag, "_mask"}, 32'(out_mask), 32'(m));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_total"}, 32'(total_count), 32'(t));
  endtask
  task automatic release_out;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("busy_after_release", 32'(busy), 0);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    cfg_we = 1;
    #1;
    chk("cfg_in_ready", 32'(in_ready), 0);
    tick;
    cfg_we = 0;
    chk("cfg_total_clear", 32'(total_count), 0);
  endtask
  initial begin
    tick;
    tick;
    reset = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    result("rst", 16'h0, 5'd0, 16'h0);
    start(16'hA800);
    chk("scan_busy", 32'(busy), 1);
    chk("scan_in_ready", 32'(in_ready), 0);
    wait_done(1);
    result("default", 16'h2800, 5'd2, 16'd2);
    in_valid = 1;
    in_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      result("hold", 16'h2800, 5'd2, 16'd2);
    end
    in_valid = 0;
    release_out;
    tick;
    chk("no_second_accept", 32'(busy), 0);
    chk("no_second_total", 32'(total_count), 2);
    cfg(8'b101, 4'd3, 1'b0);
    start(16'hA800);
    wait_done(1);
    result("nonoverlap", 16'h2000, 5'd1, 16'd1);
    release_out;
    cfg(8'b101, 4'd3, 1'b1);
    start(16'h0002);
    wait_done(1);
    result("span_first", 16'h0000, 5'd0, 16'd0);
    release_out;
    start(16'h8000);
    wait_done(1);
    result("span_second", 16'h8000, 5'd1, 16'd1);
    release_out;
    start(16'hA800);
    repeat (5) tick;
    reset = 1;
    tick;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    result("midrst", 16'h0, 5'd0, 16'h0);
    reset = 0;
    start(16'hA800);
    wait_done(1);
    result("after_rst", 16'h2800, 5'd2, 16'd2);
    release_out;
    start(16'hA800);
    cfg_pattern = 8'h15;
    cfg_len = 4'd5;
    cfg_overlap = 0;
    cfg_we = 1;
    tick;
    cfg_we = 0;
    wait_done(2);
    result("cfg_in_scan", 16'h2800, 5'd2, 16'd4);
    release_out;
    cfg(8'b110, 4'd0, 1'b1);
    start(16'hA800);
    wait_done(1);
    result("len_min", 16'h5400, 5'd3, 16'd3);
    release_out;
    cfg(8'h00, 4'd2, 1'b0);
    start(16'h0000);
    wait_done(1);
    result("zero_pat", 16'hFFFF, 5'd16, 16'd16);
    release_out;
    cfg(8'hFF, 4'd15, 1'b1);
    start(16'hFFFF);
    wait_done(1);
    result("len_max", 16'h01FF, 5'd9, 16'd9);
    release_out;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
